// File: rtl/display_scan_controller.sv
// Four-digit multiplexed display scanner with PWM brightness, per-digit blanking
// and a double-buffered digit word that only changes on frame boundaries.
module display_scan_controller #(
    parameter int SUB_CYCLES = 12500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [2:0]  brightness,
    input  logic [3:0]  blank_mask,
    input  logic        load_valid,
    input  logic [15:0] load_data,
    output logic        load_ready,
    output logic [1:0]  digit_sel,
    output logic [3:0]  nibble,
    output logic [3:0]  an_n,
    output logic        frame_start,
    output logic        update_done
);

    localparam int SUB_W = (SUB_CYCLES > 1) ? $clog2(SUB_CYCLES) : 1;
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SUB_CYCLES - 1);

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [SUB_W-1:0] sub_cnt;
    logic [SUB_W-1:0] sub_next;
    logic [2:0]       phase;
    logic [2:0]       phase_next;
    logic [1:0]       digit_next;
    logic [2:0]       bright_lat;
    logic [3:0]       mask_lat;
    logic [15:0]      active;
    logic [15:0]      shadow;
    logic             pending;
    logic             slot_start_next;
    logic             frame_next;
    logic             transfer;
    logic             copy;

    // Leaving SCAN (or sitting in IDLE) parks every counter at zero, so the
    // next SCAN entry is always cycle 0 of the digit-0 slot.
    always_comb begin
        state_next = state;
        sub_next   = '0;
        phase_next = '0;
        digit_next = '0;
        case (state)
            IDLE: begin
                if (enable) state_next = SCAN;
            end
            SCAN: begin
                if (!enable) begin
                    state_next = IDLE;
                end else begin
                    sub_next   = sub_cnt + SUB_W'(1);
                    phase_next = phase;
                    digit_next = digit_sel;
                    if (sub_cnt == SUB_LAST) begin
                        sub_next   = '0;
                        phase_next = phase + 3'd1;
                        if (phase == 3'd7) digit_next = digit_sel + 2'd1;
                    end
                end
            end
        endcase
    end

    // Copies are decided one edge early so active, frame_start and update_done
    // all change together at the start of the frame's first cycle.
    always_comb begin
        slot_start_next = (sub_next == '0) && (phase_next == 3'd0);
        frame_next      = (state_next == SCAN) && slot_start_next && (digit_next == 2'd0);
        transfer        = load_valid && !pending;
        copy            = pending && (frame_next || state_next == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            sub_cnt     <= '0;
            phase       <= '0;
            digit_sel   <= '0;
            bright_lat  <= '0;
            mask_lat    <= '0;
            active      <= '0;
            shadow      <= '0;
            pending     <= 1'b0;
            frame_start <= 1'b0;
            update_done <= 1'b0;
        end else begin
            state       <= state_next;
            sub_cnt     <= sub_next;
            phase       <= phase_next;
            digit_sel   <= digit_next;
            frame_start <= frame_next;
            update_done <= copy;
            if (slot_start_next) begin
                bright_lat <= brightness;
                mask_lat   <= blank_mask;
            end
            if (copy) begin
                active  <= shadow;
                pending <= 1'b0;
            end else if (transfer) begin
                shadow  <= load_data;
                pending <= 1'b1;
            end
        end
    end

    always_comb begin
        an_n = 4'b1111;
        if (state == SCAN && phase <= bright_lat && !mask_lat[digit_sel]) begin
            an_n[digit_sel] = 1'b0;
        end
    end

    assign load_ready = ~pending;
    assign nibble     = active[{digit_sel, 2'b00} +: 4];

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench for display_scan_controller at SUB_CYCLES = 2 (16-cycle slot,
// 64-cycle frame); loaded words go through a scoreboard queue.
module tb_display_scan_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [2:0]  brightness;
    logic [3:0]  blank_mask;
    logic        load_valid;
    logic [15:0] load_data;
    logic        load_ready;
    logic [1:0]  digit_sel;
    logic [3:0]  nibble;
    logic [3:0]  an_n;
    logic        frame_start;
    logic        update_done;

    int          compared   = 0;
    int          mismatched = 0;
    logic [15:0] exp_q[$];
    logic [15:0] shown      = 16'h0000;
    logic        saw_update = 1'b0;

    display_scan_controller #(.SUB_CYCLES(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .brightness  (brightness),
        .blank_mask  (blank_mask),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_ready  (load_ready),
        .digit_sel   (digit_sel),
        .nibble      (nibble),
        .an_n        (an_n),
        .frame_start (frame_start),
        .update_done (update_done)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, expv);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [15:0] data);
        load_valid = valid;
        load_data  = data;
    endtask

    // Advance one cycle; any update_done pulse retires the oldest queued word.
    task automatic tick();
        logic [15:0] w;
        @(posedge clk);
        #1;
        saw_update = update_done;
        if (update_done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checkOutput("sb_unexpected_update", 32'(update_done), 32'h0);
            end else begin
                w = exp_q.pop_front();
                checkOutput("sb_nibble0", 32'(nibble), 32'(w[3:0]));
                shown = w;
            end
        end
    endtask

    // Run one whole frame from its first cycle, checking scan order, nibbles and
    // per-digit on-time; optionally offers up to two loads at given cycles.
    task automatic runFrame(input logic [4:0] e0, input logic [4:0] e1,
                            input logic [4:0] e2, input logic [4:0] e3,
                            input int la, input logic [15:0] wa, input logic aa,
                            input int lb, input logic [15:0] wb, input logic ab,
                            input logic hold_b);
        int          low[4];
        logic [3:0]  exp_an;
        for (int k = 0; k < 4; k++) low[k] = 0;
        for (int c = 0; c < 64; c++) begin
            int d;
            d = c / 16;
            checkOutput("frame_start", 32'(frame_start), 32'(c == 0));
            if (c != 0) checkOutput("update_mid_frame", 32'(update_done), 32'h0);
            checkOutput("digit_sel", 32'(digit_sel), 32'(d));
            checkOutput("nibble", 32'(nibble), 32'(shown[4*d +: 4]));
            exp_an = ~(4'b0001 << d);
            if (an_n !== 4'b1111) checkOutput("an_n_digit", 32'(an_n), 32'(exp_an));
            for (int k = 0; k < 4; k++) if (an_n[k] === 1'b0) low[k]++;
            applyStimulus(hold_b && lb >= 0 && c > lb, load_data);
            if (aa && la >= 0 && c == la + 1) checkOutput("load_ready_fall", 32'(load_ready), 32'h0);
            if (c == la) begin
                checkOutput("load_ready_a", 32'(load_ready), 32'(aa));
                applyStimulus(1'b1, wa);
                if (aa) exp_q.push_back(wa);
            end
            if (c == lb) begin
                checkOutput("load_ready_b", 32'(load_ready), 32'(ab));
                applyStimulus(1'b1, wb);
                if (ab) exp_q.push_back(wb);
            end
            tick();
        end
        checkOutput("low_cycles_d0", 32'(low[0]), 32'(e0));
        checkOutput("low_cycles_d1", 32'(low[1]), 32'(e1));
        checkOutput("low_cycles_d2", 32'(low[2]), 32'(e2));
        checkOutput("low_cycles_d3", 32'(low[3]), 32'(e3));
    endtask

    initial begin
        rst        = 1'b1;
        enable     = 1'b0;
        brightness = 3'd7;
        blank_mask = 4'b0000;
        applyStimulus(1'b0, 16'h0000);
        #12;
        checkOutput("rst_an_n", 32'(an_n), 32'hF);
        checkOutput("rst_load_ready", 32'(load_ready), 32'h1);
        checkOutput("rst_nibble", 32'(nibble), 32'h0);
        checkOutput("rst_frame_start", 32'(frame_start), 32'h0);
        checkOutput("rst_update_done", 32'(update_done), 32'h0);
        checkOutput("rst_digit_sel", 32'(digit_sel), 32'h0);
        rst = 1'b0;
        tick();
        checkOutput("idle_an_n", 32'(an_n), 32'hF);

        // Full brightness walk, then brightness changes at frame starts
        enable = 1'b1;
        tick();
        checkOutput("first_scan_an_n", 32'(an_n), 32'hE);
        runFrame(16, 16, 16, 16, -1, 16'h0, 1'b0, -1, 16'h0, 1'b0, 1'b0);
        brightness = 3'd0;
        runFrame(16, 2, 2, 2, -1, 16'h0, 1'b0, -1, 16'h0, 1'b0, 1'b0);
        brightness = 3'd3;
        runFrame(2, 8, 8, 8, -1, 16'h0, 1'b0, -1, 16'h0, 1'b0, 1'b0);
        brightness = 3'd7;
        runFrame(8, 16, 16, 16, -1, 16'h0, 1'b0, -1, 16'h0, 1'b0, 1'b0);

        // Double-buffered loads: mid-frame, refused while pending, on frame_start, held across boundary
        runFrame(16, 16, 16, 16, 10, 16'h1234, 1'b1, 30, 16'h5555, 1'b0, 1'b0);
        runFrame(16, 16, 16, 16, 0, 16'hABCD, 1'b1, 40, 16'h9876, 1'b0, 1'b1);
        runFrame(16, 16, 16, 16, 0, 16'h9876, 1'b1, -1, 16'h0, 1'b0, 1'b0);
        runFrame(16, 16, 16, 16, -1, 16'h0, 1'b0, -1, 16'h0, 1'b0, 1'b0);

        blank_mask = 4'b0100;
        runFrame(16, 16, 0, 16, -1, 16'h0, 1'b0, -1, 16'h0, 1'b0, 1'b0);

        // Drop enable mid digit-2 slot
        blank_mask = 4'b0000;
        for (int i = 0; i < 40; i++) tick();
        checkOutput("mid_slot2_an_n", 32'(an_n), 32'hB);
        enable = 1'b0;
        tick();
        checkOutput("disable_an_n", 32'(an_n), 32'hF);
        checkOutput("disable_digit_sel", 32'(digit_sel), 32'h0);

        // Load while idle copies without waiting for a frame
        checkOutput("idle_load_ready", 32'(load_ready), 32'h1);
        applyStimulus(1'b1, 16'h0F0F);
        exp_q.push_back(16'h0F0F);
        tick();
        applyStimulus(1'b0, 16'h0F0F);
        checkOutput("idle_pending", 32'(load_ready), 32'h0);
        saw_update = 1'b0;
        for (int i = 0; i < 4 && !saw_update; i++) tick();
        checkOutput("idle_update_seen", 32'(saw_update), 32'h1);
        checkOutput("idle_ready_again", 32'(load_ready), 32'h1);

        enable = 1'b1;
        tick();
        checkOutput("reenable_frame_start", 32'(frame_start), 32'h1);
        checkOutput("reenable_digit_sel", 32'(digit_sel), 32'h0);
        checkOutput("reenable_an_n", 32'(an_n), 32'hE);
        checkOutput("reenable_nibble", 32'(nibble), 32'hF);

        // Reset mid-frame with a word pending discards it
        for (int i = 0; i < 20; i++) tick();
        checkOutput("pre_rst_ready", 32'(load_ready), 32'h1);
        applyStimulus(1'b1, 16'hBEEF);
        tick();
        applyStimulus(1'b0, 16'h0000);
        checkOutput("pre_rst_pending", 32'(load_ready), 32'h0);
        #1 rst = 1'b1;
        #1;
        checkOutput("async_rst_an_n", 32'(an_n), 32'hF);
        checkOutput("async_rst_ready", 32'(load_ready), 32'h1);
        checkOutput("async_rst_nibble", 32'(nibble), 32'h0);
        checkOutput("async_rst_frame_start", 32'(frame_start), 32'h0);
        enable = 1'b0;
        #2 rst = 1'b0;
        shown = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("post_rst_an_n", 32'(an_n), 32'hF);
            checkOutput("post_rst_nibble", 32'(nibble), 32'h0);
            checkOutput("post_rst_update", 32'(update_done), 32'h0);
        end
        enable = 1'b1;
        tick();
        runFrame(16, 16, 16, 16, -1, 16'h0, 1'b0, -1, 16'h0, 1'b0, 1'b0);

        checkOutput("sb_drained", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/display_scan_controller.md
DISPLAY_SCAN_CONTROLLER -- requirements
Module: display_scan_controller

Interface
REQ-001 SHALL have parameter SUB_CYCLES, default 12500: clock cycles per brightness sub-slot; legal range >= 1.
REQ-002 SHALL define one digit slot as SLOT_CYCLES = 8*SUB_CYCLES cycles and one frame as 4 slots.
REQ-003 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port enable  in  1  1 = scan display, 0 = blank and hold.
REQ-006 SHALL have port brightness  in  3  duty level; 0 = dimmest (1/8 on), 7 = full on.
REQ-007 SHALL have port blank_mask  in  4  bit k = 1 forces digit k dark.
REQ-008 SHALL have port load_valid  in  1  new digit word offered.
REQ-009 SHALL have port load_data  in  16  four hex nibbles; digit k = bits [4k+3:4k].
REQ-010 SHALL have port load_ready  out  1  shadow buffer free.
REQ-011 SHALL have port digit_sel  out  2  index of the digit currently scanned; feeds segment driver.
REQ-012 SHALL have port nibble  out  4  active-buffer nibble for digit_sel.
REQ-013 SHALL have port an_n  out  4  active-low digit enables; at most one bit low.
REQ-014 SHALL have port frame_start  out  1  one-cycle pulse on first cycle of each frame.
REQ-015 SHALL have port update_done  out  1  one-cycle pulse when shadow is copied to active.

Function
REQ-016 SHALL implement states IDLE and SCAN; IDLE -> SCAN when enable = 1; SCAN -> IDLE in the cycle after enable samples 0.
REQ-017 In IDLE, SHALL hold sub-counter, phase and digit_sel at 0 and an_n = 4'b1111.
REQ-018 First SCAN cycle SHALL be cycle 0 of the digit-0 slot, with frame_start = 1.
REQ-019 In SCAN, SHALL count the sub-counter 0..SUB_CYCLES-1, then advance phase 0..7; at the end of phase 7, SHALL advance digit_sel 0->1->2->3->0 with wrap.
REQ-020 SHALL latch brightness and blank_mask on cycle 0 of every slot; mid-slot changes SHALL NOT affect the current slot.
REQ-021 an_n[digit_sel] SHALL be 0 only when state = SCAN, phase <= latched brightness, and latched blank_mask[digit_sel] = 0; all other an_n bits SHALL be 1.
REQ-022 nibble SHALL equal active[4*digit_sel+3 : 4*digit_sel] in every cycle, including IDLE.
REQ-023 load_ready SHALL equal NOT pending; a transfer occurs when load_valid & load_ready, capturing load_data to shadow and setting pending.
REQ-024 In SCAN with pending = 1, SHALL copy shadow to active on a frame_start cycle, clear pending, and pulse update_done in that same cycle; the new value SHALL be visible from that frame onward.
REQ-025 In IDLE with pending = 1, SHALL copy shadow to active on the next cycle and pulse update_done.
REQ-026 A transfer that occurs on a frame_start cycle SHALL go to shadow only and SHALL apply at the following frame boundary; active SHALL never change mid-frame.
REQ-027 enable dropping mid-slot SHALL abort the slot; re-enable SHALL restart at digit 0, phase 0, with frame_start.
REQ-028 All outputs SHALL be driven from registers or from a direct decode of registered state; no combinational path SHALL exist from load_valid to load_ready.

Reset
REQ-029 On rst = 1, SHALL immediately force: state IDLE, active = 16'h0000, shadow = 16'h0000, pending = 0, counters = 0, digit_sel = 0, nibble = 0, an_n = 4'b1111, frame_start = 0, update_done = 0, load_ready = 1.
REQ-030 Reset asserted mid-frame or mid-transfer SHALL discard any pending data; after release, the block SHALL resume from IDLE.

Verification (SUB_CYCLES = 2: slot = 16 cycles, frame = 64)
REQ-031 Reset, enable = 1, brightness = 7, blank_mask = 0 -> an_n walks 1110, 1101, 1011, 0111, each for 16 cycles; frame_start every 64 cycles.
REQ-032 brightness = 0 -> each digit is low for 2 of 16 cycles (phase 0 only); brightness = 3 -> low for 8 cycles.
REQ-033 In SCAN, load 16'h1234 mid-frame -> load_ready falls next cycle; nibbles remain 0 until the next frame_start; update_done coincides with frame_start; digits 0..3 then show 4, 3, 2, 1; load_ready rises again.
REQ-034 Offer a second load while pending -> no transfer; load_valid held through the boundary -> accepted after update_done; a load on the frame_start cycle -> applied one frame later.
REQ-035 blank_mask = 4'b0100 -> an_n[2] stays 1 through the digit-2 slot; timing of other digits is unchanged.
REQ-036 Deassert enable mid-slot of digit 2, or assert rst mid-frame with pending = 1 -> an_n = 1111 next cycle (immediately for rst); re-enable restarts at digit 0 with frame_start; after rst, active = 0 and load_ready = 1.
